prefetch_queue: RTL and testbench

PREFETCH_QUEUE -- requirements
Module: prefetch_queue

---
 rtl/v6502_pkg.sv | 16 +
 rtl/pfq_ram.sv | 30 +++
 rtl/prefetch_queue.sv | 181 ++++++++++++++++++
 tb/tb_prefetch_queue.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/v6502_pkg.sv
// Shared widths and the fetch-state enum for the 6502 front end.
package v6502_pkg;

    localparam int unsigned PC_W      = 16;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned PFQ_DEPTH = 16;
    localparam int unsigned PTR_W     = 4;
    localparam int unsigned CNT_W     = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/pfq_ram.sv
// 16x8 byte store for the prefetch queue: one synchronous write port and
// three asynchronous read ports. Contents are deliberately not reset.
module pfq_ram
    import v6502_pkg::*;
(
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [PTR_W-1:0]  waddr_i,
    input  logic [BYTE_W-1:0] wdata_i,
    input  logic [PTR_W-1:0]  raddr0_i,
    input  logic [PTR_W-1:0]  raddr1_i,
    input  logic [PTR_W-1:0]  raddr2_i,
    output logic [BYTE_W-1:0] rdata0_o,
    output logic [BYTE_W-1:0] rdata1_o,
    output logic [BYTE_W-1:0] rdata2_o
);

    logic [BYTE_W-1:0] mem_q [PFQ_DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];
    assign rdata2_o = mem_q[raddr2_i];

endmodule

// File: rtl/prefetch_queue.sv
// Byte prefetch queue feeding the decoder, with a single-outstanding-read fetch FSM.
// Optional deq_err output is built when PREFETCH_DEQ_CHECK_EN is defined.
module prefetch_queue
    import v6502_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
    parameter int unsigned     DEPTH    = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic [PC_W-1:0]   mem_addr,
    input  logic [BYTE_W-1:0] mem_rdata,
    input  logic              mem_valid,
    input  logic              flush,
    input  logic [PC_W-1:0]   flush_pc,
    input  logic              deq,
    input  logic [1:0]        deq_len,
`ifdef PREFETCH_DEQ_CHECK_EN
    output logic              deq_err,
`endif
    output logic [BYTE_W-1:0] out_b0,
    output logic [BYTE_W-1:0] out_b1,
    output logic [BYTE_W-1:0] out_b2,
    output logic [CNT_W-1:0]  out_count,
    output logic [PC_W-1:0]   out_pc
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fetch_state_e state_q, state_d;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]  out_pc_q, out_pc_d;
    logic [PC_W-1:0]  drop_addr_q, drop_addr_d;

    logic             push;
    logic             deq_ok;
    logic [CNT_W-1:0] deq_amt;

    logic [BYTE_W-1:0] rd0, rd1, rd2;

    assign deq_amt = {{(CNT_W-2){1'b0}}, deq_len};
    // Flush wins over both push and deq; an ignored deq leaves everything untouched.
    assign push    = (state_q == WAIT) && mem_valid && !flush;
    assign deq_ok  = deq && !flush && (deq_amt <= count_q);

    // ------------------------------------------------------------------
    // Datapath next state
    // ------------------------------------------------------------------
    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        fetch_pc_d  = fetch_pc_q;
        out_pc_d    = out_pc_q;
        drop_addr_d = drop_addr_q;

        if (flush) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            fetch_pc_d = flush_pc;
            out_pc_d   = flush_pc;
        end else begin
            if (push) begin
                wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                fetch_pc_d = fetch_pc_q + PC_W'(1);
            end
            if (deq_ok) begin
                rd_ptr_d = rd_ptr_q + {{(PTR_W-2){1'b0}}, deq_len};
                out_pc_d = out_pc_q + {{(PC_W-2){1'b0}}, deq_len};
            end
            count_d = count_q + CNT_W'(push) - (deq_ok ? deq_amt : '0);
        end

        // The abandoned read keeps its address on the bus until it returns.
        if ((state_q == WAIT) && flush && !mem_valid) begin
            drop_addr_d = fetch_pc_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            fetch_pc_q  <= RESET_PC;
            out_pc_q    <= RESET_PC;
            drop_addr_q <= RESET_PC;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            fetch_pc_q  <= fetch_pc_d;
            out_pc_q    <= out_pc_d;
            drop_addr_q <= drop_addr_d;
        end
    end

    // ------------------------------------------------------------------
    // Fetch FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (flush || (count_q < FULL_CNT)) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_valid) begin
                    state_d = (count_d < FULL_CNT) ? WAIT : IDLE;
                end else if (flush) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (mem_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req  = (state_q != IDLE);
        mem_addr = (state_q == DROP) ? drop_addr_q : fetch_pc_q;
    end

    // ------------------------------------------------------------------
    // Storage and decoder-facing outputs
    // ------------------------------------------------------------------
    pfq_ram u_ram (
        .clk_i    (clk),
        .we_i     (push),
        .waddr_i  (wr_ptr_q),
        .wdata_i  (mem_rdata),
        .raddr0_i (rd_ptr_q),
        .raddr1_i (rd_ptr_q + PTR_W'(1)),
        .raddr2_i (rd_ptr_q + PTR_W'(2)),
        .rdata0_o (rd0),
        .rdata1_o (rd1),
        .rdata2_o (rd2)
    );

    // Slots beyond the held byte count read as zero rather than stale RAM.
    assign out_b0    = (count_q > CNT_W'(0)) ? rd0 : '0;
    assign out_b1    = (count_q > CNT_W'(1)) ? rd1 : '0;
    assign out_b2    = (count_q > CNT_W'(2)) ? rd2 : '0;
    assign out_count = count_q;
    assign out_pc    = out_pc_q;

`ifdef PREFETCH_DEQ_CHECK_EN
    logic deq_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deq_err_q <= 1'b0;
        end else begin
            deq_err_q <= deq && !flush && (deq_amt > count_q);
        end
    end

    assign deq_err = deq_err_q;
`endif

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue: fill, drain, flush/drop, underflow and PC wrap.
module tb_prefetch_queue;

    logic        clk;
    logic        reset;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        mem_valid;
    logic        flush;
    logic [15:0] flush_pc;
    logic        deq;
    logic [1:0]  deq_len;
    logic [7:0]  out_b0, out_b1, out_b2;
    logic [4:0]  out_count;
    logic [15:0] out_pc;
`ifdef PREFETCH_DEQ_CHECK_EN
    logic        deq_err;
`endif

    int total = 0;
    int bad   = 0;

    prefetch_queue #(
        .RESET_PC (16'h0000),
        .DEPTH    (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid),
        .flush     (flush),
        .flush_pc  (flush_pc),
        .deq       (deq),
        .deq_len   (deq_len),
`ifdef PREFETCH_DEQ_CHECK_EN
        .deq_err   (deq_err),
`endif
        .out_b0    (out_b0),
        .out_b1    (out_b1),
        .out_b2    (out_b2),
        .out_count (out_count),
        .out_pc    (out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] dat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // One-wait-state read: req seen, one idle cycle, then data.
    task automatic serve(input logic [7:0] d, input logic [15:0] a);
        chk("serve_req", {31'd0, mem_req}, 32'd1);
        chk("serve_addr", {16'd0, mem_addr}, {16'd0, a});
        tick();
        chk("serve_addr_hold", {16'd0, mem_addr}, {16'd0, a});
        mem_valid = 1'b1;
        mem_rdata = d;
        tick();
        mem_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] a;

        reset     = 1'b1;
        mem_rdata = 8'h00;
        mem_valid = 1'b0;
        flush     = 1'b0;
        flush_pc  = 16'h0000;
        deq       = 1'b0;
        deq_len   = 2'd0;
        tick();
        tick();

        // Reset state
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_addr", {16'd0, mem_addr}, 32'h0000);
        chk("rst_count", {27'd0, out_count}, 32'd0);
        chk("rst_pc", {16'd0, out_pc}, 32'h0000);
        chk("rst_b0", {24'd0, out_b0}, 32'h00);
`ifdef PREFETCH_DEQ_CHECK_EN
        chk("rst_deq_err", {31'd0, deq_err}, 32'd0);
`endif
        reset = 1'b0;
        tick();

        // Three bytes at 0000..0002
        serve(8'hA9, 16'h0000);
        serve(8'h05, 16'h0001);
        serve(8'h8D, 16'h0002);
        chk("three_count", {27'd0, out_count}, 32'd3);
        chk("three_b0", {24'd0, out_b0}, 32'hA9);
        chk("three_b1", {24'd0, out_b1}, 32'h05);
        chk("three_b2", {24'd0, out_b2}, 32'h8D);
        chk("three_pc", {16'd0, out_pc}, 32'h0000);

        // Zero-wait fill to 16
        for (int i = 3; i < 16; i++) begin
            chk("fill_addr", {16'd0, mem_addr}, i);
            mem_valid = 1'b1;
            mem_rdata = dat(16'(i));
            tick();
        end
        chk("full_count", {27'd0, out_count}, 32'd16);
        chk("full_req", {31'd0, mem_req}, 32'd0);
        chk("full_addr", {16'd0, mem_addr}, 32'h0010);
        tick();
        mem_valid = 1'b0;
        chk("idle_valid_ignored", {27'd0, out_count}, 32'd16);

        // Dequeue two from a full queue
        deq = 1'b1;
        deq_len = 2'd2;
        tick();
        deq = 1'b0;
        chk("deq2_pc", {16'd0, out_pc}, 32'h0002);
        chk("deq2_count", {27'd0, out_count}, 32'd14);
        chk("deq2_b0", {24'd0, out_b0}, 32'h8D);
        chk("deq2_b1", {24'd0, out_b1}, {24'd0, dat(16'h0003)});
        chk("deq2_b2", {24'd0, out_b2}, {24'd0, dat(16'h0004)});
        tick();
        chk("resume_req", {31'd0, mem_req}, 32'd1);
        chk("resume_addr", {16'd0, mem_addr}, 32'h0010);

        // Flush while pending, with a same-cycle deq that must be discarded
        flush = 1'b1;
        flush_pc = 16'hC000;
        deq = 1'b1;
        deq_len = 2'd1;
        tick();
        flush = 1'b0;
        deq = 1'b0;
        chk("flush_count", {27'd0, out_count}, 32'd0);
        chk("flush_pc", {16'd0, out_pc}, 32'hC000);
        chk("drop_req", {31'd0, mem_req}, 32'd1);
        chk("drop_addr", {16'd0, mem_addr}, 32'h0010);
        chk("flush_b0", {24'd0, out_b0}, 32'h00);
        tick();
        chk("drop_addr_hold", {16'd0, mem_addr}, 32'h0010);
        mem_valid = 1'b1;
        mem_rdata = 8'hEE;
        tick();
        mem_valid = 1'b0;
        chk("drop_discard_count", {27'd0, out_count}, 32'd0);
        chk("drop_idle_req", {31'd0, mem_req}, 32'd0);
        tick();
        chk("post_flush_req", {31'd0, mem_req}, 32'd1);
        chk("post_flush_addr", {16'd0, mem_addr}, 32'hC000);
        mem_valid = 1'b1;
        mem_rdata = 8'h42;
        chk("pre_push_count", {27'd0, out_count}, 32'd0);
        tick();
        mem_valid = 1'b0;
        chk("one_count", {27'd0, out_count}, 32'd1);
        chk("one_b0", {24'd0, out_b0}, 32'h42);
        chk("one_b1_masked", {24'd0, out_b1}, 32'h00);
        chk("one_b2_masked", {24'd0, out_b2}, 32'h00);
        chk("one_pc", {16'd0, out_pc}, 32'hC000);
        chk("one_next_addr", {16'd0, mem_addr}, 32'hC001);

        // Over-long deq is ignored
        deq = 1'b1;
        deq_len = 2'd3;
        tick();
        deq = 1'b0;
        chk("bad_deq_count", {27'd0, out_count}, 32'd1);
        chk("bad_deq_pc", {16'd0, out_pc}, 32'hC000);
        chk("bad_deq_b0", {24'd0, out_b0}, 32'h42);
`ifdef PREFETCH_DEQ_CHECK_EN
        chk("deq_err_pulse", {31'd0, deq_err}, 32'd1);
`endif
        tick();
`ifdef PREFETCH_DEQ_CHECK_EN
        chk("deq_err_clear", {31'd0, deq_err}, 32'd0);
`endif

        // Flush to FFF0, then wrap both the PC and the pointers
        flush = 1'b1;
        flush_pc = 16'hFFF0;
        tick();
        flush = 1'b0;
        chk("drop2_addr", {16'd0, mem_addr}, 32'hC001);
        mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
        tick();
        for (int i = 0; i < 14; i++) begin
            a = 16'hFFF0 + 16'(i);
            chk("wrap_fill_addr", {16'd0, mem_addr}, {16'd0, a});
            mem_valid = 1'b1;
            mem_rdata = dat(a);
            tick();
        end
        mem_valid = 1'b0;
        chk("wrap_fill_count", {27'd0, out_count}, 32'd14);
        deq = 1'b1;
        deq_len = 2'd3;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        deq = 1'b0;
        chk("drain_count", {27'd0, out_count}, 32'd2);
        chk("drain_pc", {16'd0, out_pc}, 32'hFFFC);
        chk("drain_b0", {24'd0, out_b0}, {24'd0, dat(16'hFFFC)});
        chk("drain_b1", {24'd0, out_b1}, {24'd0, dat(16'hFFFD)});
        chk("drain_b2_masked", {24'd0, out_b2}, 32'h00);
        for (int i = 0; i < 4; i++) begin
            a = 16'hFFFE + 16'(i);
            chk("pc_wrap_addr", {16'd0, mem_addr}, {16'd0, a});
            mem_valid = 1'b1;
            mem_rdata = dat(a);
            tick();
        end
        mem_valid = 1'b0;
        chk("pc_wrap_count", {27'd0, out_count}, 32'd6);
        chk("pc_wrap_next", {16'd0, mem_addr}, 32'h0002);
        deq = 1'b1;
        deq_len = 2'd3;
        tick();
        deq = 1'b0;
        chk("ptr_wrap_pc", {16'd0, out_pc}, 32'hFFFF);
        chk("ptr_wrap_count", {27'd0, out_count}, 32'd3);
        chk("ptr_wrap_b0", {24'd0, out_b0}, {24'd0, dat(16'hFFFF)});
        chk("ptr_wrap_b1", {24'd0, out_b1}, {24'd0, dat(16'h0000)});
        chk("ptr_wrap_b2", {24'd0, out_b2}, {24'd0, dat(16'h0001)});

        // Simultaneous push and deq
        mem_valid = 1'b1;
        mem_rdata = dat(16'h0002);
        deq = 1'b1;
        deq_len = 2'd2;
        tick();
        mem_valid = 1'b0;
        deq = 1'b0;
        chk("pushdeq_count", {27'd0, out_count}, 32'd2);
        chk("pushdeq_pc", {16'd0, out_pc}, 32'h0001);
        chk("pushdeq_b0", {24'd0, out_b0}, {24'd0, dat(16'h0001)});
        chk("pushdeq_b1", {24'd0, out_b1}, {24'd0, dat(16'h0002)});
        chk("pushdeq_b2_masked", {24'd0, out_b2}, 32'h00);
        chk("pushdeq_addr", {16'd0, mem_addr}, 32'h0003);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
